arb_74138: RTL

Round-robin arbiter that shares one 74138 3-to-8 active-low select decoder among eight requesters. It drives the decoder's select and enable inputs so that exactly one requester's active-low line is asserted at a time, with a guaranteed dead cycle between owners. It sits between the requester-side logic (DMA, UART, SPI masters sharing a bus) and the 74138 chip-select decoder.

---
 rtl/arb_74138.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/arb_74138.sv
// Round-robin arbiter that shares one 74138 3-to-8 active-low decoder among
// eight requesters, inserting one dead cycle between successive owners.
module arb_74138 #(
  parameter int MAX_GRANT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] req_i,
  input  logic       arb_en_i,
  output logic       select_a_o,
  output logic       select_b_o,
  output logic       select_c_o,
  output logic       g1_en_o,
  output logic       g2a_en_n_o,
  output logic       g2b_en_n_o,
  output logic [7:0] gnt_o,
  output logic [2:0] gnt_id_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_GAP
  } state_e;

  localparam logic [7:0] MAX_G   = 8'(MAX_GRANT);
  localparam logic [7:0] CNT_SAT = 8'hFF;

  state_e     state_q, state_d;
  logic [2:0] owner_q, owner_d;   // drives select and gnt_id together
  logic [2:0] last_q, last_d;     // round-robin pointer
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic       g1_q, g1_d;
  logic       g2_n_q, g2_n_d;
  logic       busy_q, busy_d;

  logic       win_found;
  logic [2:0] win_id;
  logic [7:0] owner_onehot;
  logic [7:0] competitors;

  // Scans upward from the slot after the last owner, wrapping at 8; the
  // eighth probe lands on the last owner itself so it can win again.
  function automatic logic [3:0] pick_winner(input logic [7:0] req,
                                              input logic [2:0] last);
    logic       found;
    logic [2:0] win;
    logic [2:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 1; i <= 8; i++) begin
      idx = last + 3'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  assign {win_found, win_id} = pick_winner(req_i, last_q);
  assign owner_onehot        = 8'b1 << owner_q;
  assign competitors         = req_i & ~owner_onehot;

  // NOTE: every signal written here gets a default first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    g1_d    = 1'b0;
    g2_n_d  = 1'b1;
    busy_d  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_GAP: begin
        // GAP is a single dead cycle, then follows the same rule as IDLE.
        if (arb_en_i && win_found) begin
          state_d = ST_GRANT;
          owner_d = win_id;
          last_d  = win_id;
          cnt_d   = 8'd1;
          gnt_d   = 8'b1 << win_id;
          g1_d    = 1'b1;
          g2_n_d  = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_GRANT: begin
        busy_d = 1'b1;
        if (!req_i[owner_q] || (cnt_q >= MAX_G && competitors != '0)) begin
          // Enables drop with select held, giving the decoder a dead cycle.
          state_d = ST_GAP;
        end else begin
          gnt_d  = owner_onehot;
          g1_d   = 1'b1;
          g2_n_d = 1'b0;
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= 3'd7;
      cnt_q   <= '0;
      gnt_q   <= '0;
      g1_q    <= 1'b0;
      g2_n_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      g1_q    <= g1_d;
      g2_n_q  <= g2_n_d;
      busy_q  <= busy_d;
    end
  end

  assign select_a_o = owner_q[0];
  assign select_b_o = owner_q[1];
  assign select_c_o = owner_q[2];
  assign gnt_id_o   = owner_q;
  assign g1_en_o    = g1_q;
  assign g2a_en_n_o = g2_n_q;
  assign g2b_en_n_o = g2_n_q;
  assign gnt_o      = gnt_q;
  assign busy_o     = busy_q;

endmodule
